// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the timing generator and the
// display blocks that consume DrawX/DrawY.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus sync/active decode.
//   clk, reset_n : clock, synchronous active-low reset
//   adv          : advance the position by one on this edge
//   count        : registered position, 0..TOTAL-1 (reset TOTAL-1)
//   sync         : registered sync, active low, aligned with count
//   wrap         : combinational, this edge takes count from TOTAL-1 to 0
//   active_next  : combinational, the position after this edge is active
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned FP     = vga_timing_pkg::H_FP,
  parameter int unsigned SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned BP     = vga_timing_pkg::H_BP
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   adv,
  output coord_t count,
  output logic   sync,
  output logic   wrap,
  output logic   active_next
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  if (TOTAL > 1024 || TOTAL < 2) begin : g_total_check
    $error("vga_axis_counter: TOTAL outside the 10-bit counter range");
  end

  coord_t count_next;
  logic   sync_next;

  // Decode from the next-state count so sync lines up with the position
  // it describes on the same edge.
  always_comb begin
    wrap        = adv && (count == LAST);
    count_next  = count;
    if (adv) begin
      count_next = wrap ? '0 : count + coord_t'(1);
    end
    sync_next   = !((count_next >= SYNC_START) && (count_next < SYNC_END));
    active_next = (count_next < ACTIVE_END);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= LAST;
      sync  <= 1'b1;
    end else if (adv) begin
      count <= count_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60) with pixel clock-enable.
//   vga_clk, reset_n : clock, synchronous active-low reset
//   pix_ce           : pixel advance enable
//   hs, vs           : syncs, active low
//   blank            : 1 = active video
//   DrawX, DrawY     : current pixel column / line
//   line_start       : one-clock pulse when DrawX becomes 0
//   frame_start      : one-clock pulse when (DrawX,DrawY) becomes (0,0)
//   frame_cnt        : frames elapsed; counts only with VGA_FRAME_CNT_EN
//                      defined, otherwise constant 0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   pix_ce,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output vga_timing_pkg::coord_t DrawX,
  output vga_timing_pkg::coord_t DrawY,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  import vga_timing_pkg::*;

  logic h_wrap;
  logic v_wrap;
  logic h_active_next;
  logic v_active_next;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk         (vga_clk),
    .reset_n     (reset_n),
    .adv         (pix_ce),
    .count       (DrawX),
    .sync        (hs),
    .wrap        (h_wrap),
    .active_next (h_active_next)
  );

  // The line counter steps only on the edge where the pixel counter wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk         (vga_clk),
    .reset_n     (reset_n),
    .adv         (h_wrap),
    .count       (DrawY),
    .sync        (vs),
    .wrap        (v_wrap),
    .active_next (v_active_next)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (pix_ce) begin
        blank <= h_active_next && v_active_next;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-timing
// instance (16 x 11 raster) driven by the same stimulus.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic pix_ce;

  logic       hs_a, vs_a, blank_a, ls_a, fs_a;
  logic [9:0] dx_a, dy_a;
  logic [7:0] fc_a;

  logic       hs_b, vs_b, blank_b, ls_b, fs_b;
  logic [9:0] dx_b, dy_b;
  logic [1:0] fc_b;

  vga_timing_gen u_dut_a (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .hs          (hs_a),
    .vs          (vs_a),
    .blank       (blank_a),
    .DrawX       (dx_a),
    .DrawY       (dy_a),
    .line_start  (ls_a),
    .frame_start (fs_a),
    .frame_cnt   (fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE    (8),
    .H_FP        (2),
    .H_SYNC      (3),
    .H_BP        (3),
    .V_ACTIVE    (6),
    .V_FP        (1),
    .V_SYNC      (2),
    .V_BP        (2),
    .FRAME_CNT_W (2)
  ) u_dut_b (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (blank_b),
    .DrawX       (dx_b),
    .DrawY       (dy_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  obs_t ma, mb;

  int checks = 0;
  int errors = 0;

  // Statistics gathered from DUT outputs while collect is set.
  logic collect = 1'b0;
  int   cyc = 0;
  int   hs_low_a = 0;
  int   fall_x_a = -1;
  logic prev_blank_a = 1'b0;
  int   ls_n_a = 0;
  int   ls_t_a[2];
  int   blank_n_b = 0;
  int   vs_low_b = 0;
  int   fs_n_b = 0;
  int   fs_t_b[2];

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
               nm, act.x, act.y, act.hs, act.vs, act.blank, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge, written from the raster rules.
  function automatic obs_t model_step(input obs_t s, input logic ce, input logic rst,
                                      input int ha, input int hf, input int hsy, input int hb,
                                      input int va, input int vf, input int vsy, input int vb,
                                      input int fw);
    obs_t n;
    int ht, vt, nx, ny;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    n  = s;
    if (!rst) begin
      n.x = 10'(ht - 1);
      n.y = 10'(vt - 1);
      n.hs = 1'b1; n.vs = 1'b1; n.blank = 1'b0;
      n.ls = 1'b0; n.fs = 1'b0; n.fc = 8'd0;
    end else if (ce) begin
      if (int'(s.x) == ht - 1) begin
        nx = 0;
        ny = (int'(s.y) == vt - 1) ? 0 : int'(s.y) + 1;
      end else begin
        nx = int'(s.x) + 1;
        ny = int'(s.y);
      end
      n.x     = 10'(nx);
      n.y     = 10'(ny);
      n.ls    = (nx == 0);
      n.fs    = (nx == 0) && (ny == 0);
      n.hs    = !((nx >= ha + hf) && (nx < ha + hf + hsy));
      n.vs    = !((ny >= va + vf) && (ny < va + vf + vsy));
      n.blank = (nx < ha) && (ny < va);
`ifdef VGA_FRAME_CNT_EN
      if (n.fs) n.fc = 8'((int'(s.fc) + 1) % (1 << fw));
`else
      if (fw < 0) n.fc = 8'd0;
`endif
    end else begin
      n.ls = 1'b0;
      n.fs = 1'b0;
    end
    return n;
  endfunction

  task automatic step(input logic ce, input logic rst);
    reset_n = rst;
    pix_ce  = ce;
    ma = model_step(ma, ce, rst, 640, 16, 96, 48, 480, 10, 2, 33, 8);
    mb = model_step(mb, ce, rst, 8, 2, 3, 3, 6, 1, 2, 2, 2);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge presents a new output word; compare it with the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      a = '{x: dx_a, y: dy_a, hs: hs_a, vs: vs_a, blank: blank_a, ls: ls_a, fs: fs_a, fc: fc_a};
      check_obs("main_out", a, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      a = '{x: dx_b, y: dy_b, hs: hs_b, vs: vs_b, blank: blank_b, ls: ls_b, fs: fs_b, fc: {6'd0, fc_b}};
      check_obs("small_out", a, e);
    end
    if (collect) begin
      if (hs_a === 1'b0) hs_low_a++;
      if (prev_blank_a === 1'b1 && blank_a === 1'b0 && fall_x_a < 0) fall_x_a = int'(dx_a);
      prev_blank_a = blank_a;
      if (ls_a === 1'b1) begin
        if (ls_n_a < 2) ls_t_a[ls_n_a] = cyc;
        ls_n_a++;
      end
      if (blank_b === 1'b1) blank_n_b++;
      if (vs_b === 1'b0) vs_low_b++;
      if (fs_b === 1'b1) begin
        if (fs_n_b < 2) fs_t_b[fs_n_b] = cyc;
        fs_n_b++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    int exp_fc;
    reset_n = 1'b0;
    pix_ce  = 1'b0;

    // Reset, including a reset edge with pix_ce high (must not pulse).
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_int("reset_x", int'(dx_a), 799);
    check_int("reset_y", int'(dy_a), 524);
    check_int("reset_hs_vs_blank", int'({hs_a, vs_a, blank_a}), 3'b110);
    check_int("reset_pulses", int'({ls_a, fs_a}), 0);

    // Continuous pixel enable: one full line on the main instance and five
    // full frames on the small instance.
    collect = 1'b1;
    step(1'b1, 1'b1);
    check_int("first_ce_xy", int'({dx_a, dy_a}), 0);
    check_int("first_ce_flags", int'({blank_a, hs_a, vs_a, ls_a, fs_a}), 5'b11111);
    repeat (879) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    collect = 1'b0;

    check_int("hs_low_cycles", hs_low_a, 96);
    check_int("blank_fall_x", fall_x_a, 640);
    check_int("line_start_count", ls_n_a, 2);
    check_int("line_start_period", ls_t_a[1] - ls_t_a[0], 800);
    check_int("small_blank_cycles", blank_n_b, 240);
    check_int("small_vs_low_cycles", vs_low_b, 160);
    check_int("small_frame_start_count", fs_n_b, 5);
    check_int("small_frame_start_period", fs_t_b[1] - fs_t_b[0], 176);
`ifdef VGA_FRAME_CNT_EN
    exp_fc = 1;
`else
    exp_fc = 0;
`endif
    check_int("small_frame_cnt", int'(fc_b), exp_fc);

    // Half-rate pixel enable.
    repeat (100) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end

    // Reset mid-frame, hold, then a clean restart at (0,0).
    step(1'b1, 1'b0);
    check_int("midreset_xy", int'({dx_a, dy_a}), int'({10'd799, 10'd524}));
    check_int("midreset_pulses", int'({ls_a, fs_a, blank_a}), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_int("restart_xy", int'({dx_a, dy_a}), 0);
    check_int("restart_frame_start", int'({ls_a, fs_a}), 2'b11);
    step(1'b1, 1'b1);
    check_int("restart_second_px", int'({dx_a, ls_a, fs_a}), int'({10'd1, 2'b00}));
    step(1'b0, 1'b1);

    // Let the monitor consume everything outstanding.
    for (int i = 0; i < 4; i++) begin
      if (qa.size() > 0 || qb.size() > 0) @(negedge clk);
    end
    #1;
    check_int("scoreboard_drained", qa.size() + qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
